// File: rtl/prim_clock_mux_ctrl.sv
// prim_clock_mux_ctrl
// Break-before-make controller for an N-input glitch-free clock mux. It runs
// in an always-on domain and drives one-hot enables to NumClk clock gates whose
// gated outputs are OR-combined downstream. Every source switch is sequenced as
// all enables off -> quiet gap -> new enable on -> settle -> ack, so two enables
// are never high in the same cycle.
//
// Handshake: a request is a single-cycle sample of req_i (with sel_i) taken only
// while the FSM is IDLE (busy_o low and no ack pending). Every accepted request
// gets exactly one ack_o pulse; err_o pulses with it when sel_i is out of range.
// req_i/sel_i are don't-care whenever they are not sampled.
//
// Ports:
//   clk_i      in   1       always-on control clock
//   rst_i      in   1       synchronous, active-high reset
//   req_i      in   1       switch request, sampled only in IDLE
//   sel_i      in   SelW    requested source, captured with req_i
//   ack_o      out  1       one-cycle pulse: request complete
//   err_o      out  1       one-cycle pulse with ack_o: select out of range
//   busy_o     out  1       switch in progress
//   en_o       out  NumClk  one-hot or all-zero clock-gate enables
//   cur_sel_o  out  SelW    currently enabled source
//   state_o    out  2       FSM state (0 IDLE, 1 DRAIN, 2 SETTLE, 3 DONE)
module prim_clock_mux_ctrl #(
    parameter int NumClk    = 4,
    parameter int SelW      = $clog2(NumClk),
    parameter int ResetSel  = 0,
    parameter int OffCycles = 2,
    parameter int OnCycles  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [SelW-1:0]   sel_i,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [NumClk-1:0] en_o,
    output logic [SelW-1:0]   cur_sel_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [NumClk-1:0] OneEn    = {{(NumClk-1){1'b0}}, 1'b1};
    localparam logic [NumClk-1:0] ResetEn  = OneEn << ResetSel;
    localparam logic [SelW-1:0]   ResetIdx = SelW'(ResetSel);
    localparam logic [SelW:0]     NumClkW  = (SelW+1)'(NumClk);
    // Counter holds "remaining cycles minus one" so the phase ends on the
    // edge after it reads zero. SETTLE always lasts at least one cycle.
    localparam logic [7:0]        OffLoad  = 8'(OffCycles - 1);
    localparam logic [7:0]        OnLoad   = 8'((OnCycles == 0) ? 0 : OnCycles - 1);

    state_t          state;
    logic [7:0]      cnt;
    logic [SelW-1:0] tgt;

    assign state_o = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            tgt       <= ResetIdx;
            en_o      <= ResetEn;
            cur_sel_o <= ResetIdx;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses unless re-asserted below.
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        tgt <= sel_i;
                        if ({1'b0, sel_i} >= NumClkW) begin
                            ack_o <= 1'b1;
                            err_o <= 1'b1;
                        end else if (sel_i == cur_sel_o) begin
                            ack_o <= 1'b1;
                        end else begin
                            en_o   <= '0;
                            busy_o <= 1'b1;
                            cnt    <= OffLoad;
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == 8'd0) begin
                        en_o      <= OneEn << tgt;
                        cur_sel_o <= tgt;
                        cnt       <= OnLoad;
                        state     <= SETTLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == 8'd0) begin
                        // busy drops in the same cycle the ack is shown.
                        ack_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    // A request in this cycle is deliberately not accepted.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prim_clock_mux_ctrl.sv
// Directed bench for prim_clock_mux_ctrl. Two instances share clk/rst:
//   dut_a: NumClk=4, ResetSel=2, OffCycles=2, OnCycles=2
//   dut_b: NumClk=3, ResetSel=0, OffCycles=1, OnCycles=0 (out-of-range select,
//          minimum gap, zero settle)
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_prim_clock_mux_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_a = 1'b0;
    logic [1:0] sel_a = 2'd0;
    logic       ack_a, err_a, busy_a;
    logic [3:0] en_a;
    logic [1:0] cur_a, st_a;

    logic       req_b = 1'b0;
    logic [1:0] sel_b = 2'd0;
    logic       ack_b, err_b, busy_b;
    logic [2:0] en_b;
    logic [1:0] cur_b, st_b;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    prim_clock_mux_ctrl #(
        .NumClk(4), .ResetSel(2), .OffCycles(2), .OnCycles(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .sel_i(sel_a),
        .ack_o(ack_a), .err_o(err_a), .busy_o(busy_a), .en_o(en_a),
        .cur_sel_o(cur_a), .state_o(st_a)
    );

    prim_clock_mux_ctrl #(
        .NumClk(3), .ResetSel(0), .OffCycles(1), .OnCycles(0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .sel_i(sel_b),
        .ack_o(ack_b), .err_o(err_b), .busy_o(busy_b), .en_o(en_b),
        .cur_sel_o(cur_b), .state_o(st_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin : main
        int         pend;
        logic       done_cyc;
        logic       same;
        logic       exp_ack;
        logic [1:0] mcur;
        int         acks_seen;
        int         acks_exp;

        // ---------------- reset ----------------
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_en_a", 32'(en_a), 32'h4);
        chk("rst_cur_a", 32'(cur_a), 32'd2);
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        chk("rst_state_a", 32'(st_a), 32'd0);
        chk("rst_en_b", 32'(en_b), 32'h1);
        chk("rst_cur_b", 32'(cur_b), 32'd0);

        // ---------------- switch 2 -> 1 on dut_a ----------------
        req_a = 1'b1; sel_a = 2'd1;
        step();                                   // cycle k+1
        sel_a = 2'd3;                             // don't-care while busy
        chk("sw_k1_en", 32'(en_a), 32'h0);
        chk("sw_k1_busy", 32'(busy_a), 32'd1);
        chk("sw_k1_ack", 32'(ack_a), 32'd0);
        step();                                   // k+2
        chk("sw_k2_en", 32'(en_a), 32'h0);
        step();                                   // k+3
        req_a = 1'b0;
        chk("sw_k3_en", 32'(en_a), 32'h2);
        chk("sw_k3_cur", 32'(cur_a), 32'd1);
        chk("sw_k3_busy", 32'(busy_a), 32'd1);
        step();                                   // k+4
        chk("sw_k4_ack", 32'(ack_a), 32'd0);
        step();                                   // k+5
        chk("sw_k5_ack", 32'(ack_a), 32'd1);
        chk("sw_k5_busy", 32'(busy_a), 32'd0);
        chk("sw_k5_en", 32'(en_a), 32'h2);
        step();                                   // k+6
        chk("sw_k6_ack", 32'(ack_a), 32'd0);

        // ---------------- same-source request ----------------
        req_a = 1'b1; sel_a = 2'd1;
        step();
        req_a = 1'b0;
        chk("same_ack", 32'(ack_a), 32'd1);
        chk("same_err", 32'(err_a), 32'd0);
        chk("same_busy", 32'(busy_a), 32'd0);
        chk("same_en", 32'(en_a), 32'h2);
        step();
        chk("same_ack_off", 32'(ack_a), 32'd0);
        chk("same_en2", 32'(en_a), 32'h2);

        // ---------------- invalid select on dut_b ----------------
        req_b = 1'b1; sel_b = 2'd3;
        step();
        req_b = 1'b0;
        chk("inv_ack", 32'(ack_b), 32'd1);
        chk("inv_err", 32'(err_b), 32'd1);
        chk("inv_en", 32'(en_b), 32'h1);
        chk("inv_cur", 32'(cur_b), 32'd0);
        chk("inv_busy", 32'(busy_b), 32'd0);
        step();
        chk("inv_ack_off", 32'(ack_b), 32'd0);
        chk("inv_err_off", 32'(err_b), 32'd0);

        // ---------------- dut_b 0 -> 2, Off=1, On=0 ----------------
        req_b = 1'b1; sel_b = 2'd2;
        step();                                   // k+1
        chk("b_k1_en", 32'(en_b), 32'h0);
        chk("b_k1_busy", 32'(busy_b), 32'd1);
        step();                                   // k+2
        chk("b_k2_en", 32'(en_b), 32'h4);
        chk("b_k2_cur", 32'(cur_b), 32'd2);
        chk("b_k2_ack", 32'(ack_b), 32'd0);
        step();                                   // k+3: DONE
        chk("b_k3_ack", 32'(ack_b), 32'd1);
        chk("b_k3_busy", 32'(busy_b), 32'd0);
        sel_b = 2'd1;                             // request during DONE: ignored
        step();
        req_b = 1'b0;
        chk("b_done_req_ack", 32'(ack_b), 32'd0);
        chk("b_done_req_busy", 32'(busy_b), 32'd0);
        chk("b_done_req_en", 32'(en_b), 32'h4);

        // ---------------- reset mid-DRAIN on dut_a ----------------
        req_a = 1'b1; sel_a = 2'd3;
        step();
        req_a = 1'b0;
        chk("md_en", 32'(en_a), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("md_rst_en", 32'(en_a), 32'h4);
        chk("md_rst_cur", 32'(cur_a), 32'd2);
        chk("md_rst_busy", 32'(busy_a), 32'd0);
        chk("md_rst_ack", 32'(ack_a), 32'd0);
        step();
        chk("md_post_ack", 32'(ack_a), 32'd0);
        chk("md_post_en", 32'(en_a), 32'h4);

        // ---------------- random back-to-back on dut_a ----------------
        // Model: a switch acks 5 edges after acceptance (1 + Off + On); the ack
        // cycle itself refuses requests; a same-source request acks next cycle.
        pend = 0; done_cyc = 1'b0; mcur = 2'd2;
        acks_seen = 0; acks_exp = 0;
        for (int i = 0; i < 3000; i++) begin
            req_a = 1'($urandom_range(0, 1));
            sel_a = 2'($urandom_range(0, 3));
            same = 1'b0;
            if (pend == 0 && !done_cyc && req_a) begin
                if (sel_a == mcur) same = 1'b1;
                else begin
                    pend = 5;
                    mcur = sel_a;
                end
            end
            step();
            exp_ack = same;
            done_cyc = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    exp_ack = 1'b1;
                    done_cyc = 1'b1;
                end
            end
            if (exp_ack) acks_exp++;
            if (ack_a) acks_seen++;
            chk("rnd_onehot", 32'($countones(en_a) <= 1), 32'd1);
            chk("rnd_ack", 32'(ack_a), 32'(exp_ack));
            if (pend == 0) begin
                chk("rnd_cur", 32'(cur_a), 32'(mcur));
                chk("rnd_en", 32'(en_a), 32'(4'b0001 << mcur));
            end
        end
        req_a = 1'b0;
        chk("rnd_ack_count", 32'(acks_seen), 32'(acks_exp));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
